// File: rtl/sr_latch_exerciser_if.sv
// rtl/sr_latch_exerciser_if.sv - control and latch-pin bundle for the SR latch exerciser
//
// Purpose: groups the run-control handshake (start/mode -> busy/done/pass/
// err_count/last_op) and the latch pins (s_out/r_out out, q_in/qn_in back).
// Ports (signals):
//   start, mode        : run request and op-source select (master -> slave)
//   q_in, qn_in        : latch Q/Qn, asynchronous to clk (master -> slave)
//   s_out, r_out       : latch S/R drive (slave -> master)
//   busy, done, pass   : run status (slave -> master)
//   err_count          : saturating mismatch count of the last run
//   last_op            : op code currently or most recently executed
// Modports: slave = the exerciser, master = whatever surrounds it.
interface sr_latch_exerciser_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             mode;
  logic             q_in;
  logic             qn_in;
  logic             s_out;
  logic             r_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       last_op;

  modport master (
    output start, mode, q_in, qn_in,
    input  s_out, r_out, busy, done, pass, err_count, last_op
  );

  modport slave (
    input  start, mode, q_in, qn_in,
    output s_out, r_out, busy, done, pass, err_count, last_op
  );
endinterface

// File: rtl/sr_latch_exerciser.sv
// rtl/sr_latch_exerciser.sv - clocked stimulus driver and checker for a NOR SR latch
//
// Purpose: runs NUM_OPS operations against an unclocked SR latch. Each op
// drives S/R for SETTLE_CYCLES, releases for SETTLE_CYCLES, then checks the
// synchronized Q/Qn against the expected latch state for one cycle.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sr_latch_exerciser_if.slave (start, mode, q_in, qn_in in;
//           s_out, r_out, busy, done, pass, err_count, last_op out)
module sr_latch_exerciser #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_OPS       = 16,
  parameter int ERR_W         = 8
) (
  input logic                clk,
  input logic                rst_n,
  sr_latch_exerciser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    RELEASE = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      OPS_N    = 16'(NUM_OPS);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [7:0]       LFSR_SEED = 8'hA5;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      op_idx, op_idx_n;
  logic [7:0]       lfsr, lfsr_n;
  logic             exp_q, exp_q_n;
  logic             exp_valid, exp_valid_n;
  logic             s_q, s_n, r_q, r_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             pass_q, pass_n;
  logic [ERR_W-1:0] err_q, err_n;
  logic [1:0]       last_op_q, last_op_n;

  logic             q_meta, q_sync, qn_meta, qn_sync;

  // Combinational helpers
  logic             load_op;
  logic [15:0]      next_idx;
  logic [15:0]      idx_inc;
  logic [1:0]       op;
  logic             mismatch;

  // Fixed pattern: SET, HOLD, RESET, HOLD
  function automatic logic [1:0] pattern_op(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'b01;
      2'd2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Q/Qn are asynchronous to clk, so both go through two flops before use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta  <= 1'b0;
      q_sync  <= 1'b0;
      qn_meta <= 1'b0;
      qn_sync <= 1'b0;
    end else begin
      q_meta  <= bus.q_in;
      q_sync  <= q_meta;
      qn_meta <= bus.qn_in;
      qn_sync <= qn_meta;
    end
  end

  // Q == Qn (invalid latch state) can never satisfy this, so it always counts
  assign mismatch = exp_valid && !((q_sync == exp_q) && (qn_sync == ~exp_q));
  assign idx_inc  = op_idx + 16'd1;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    op_idx_n    = op_idx;
    lfsr_n      = lfsr;
    exp_q_n     = exp_q;
    exp_valid_n = exp_valid;
    s_n         = 1'b0;
    r_n         = 1'b0;
    busy_n      = busy_q;
    done_n      = 1'b0;
    pass_n      = pass_q;
    err_n       = err_q;
    last_op_n   = last_op_q;
    load_op     = 1'b0;
    next_idx    = op_idx;
    op          = 2'b00;

    case (state)
      IDLE: begin
        if (bus.start) begin
          err_n       = '0;
          exp_valid_n = 1'b0;
          op_idx_n    = 16'd0;
          pass_n      = 1'b0;
          busy_n      = 1'b1;
          cnt_n       = '0;
          state_n     = DRIVE;
          load_op     = 1'b1;
          next_idx    = 16'd0;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          s_n   = s_q;
          r_n   = r_q;
        end
      end
      RELEASE: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = CHECK;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch && (err_q != ERR_MAX)) begin
          err_n = err_q + ERR_W'(1);
        end
        op_idx_n = idx_inc;
        if (idx_inc == OPS_N) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n  = DRIVE;
          load_op  = 1'b1;
          next_idx = idx_inc;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Op selection happens on every entry to DRIVE; the decode into S/R can
    // only ever raise one of the two.
    if (load_op) begin
      if (bus.mode) begin
        op     = lfsr[1:0];
        lfsr_n = lfsr_step(lfsr);
      end else begin
        op = pattern_op(next_idx[1:0]);
      end
      last_op_n = op;
      s_n       = (op == 2'b01);
      r_n       = (op == 2'b10);
      if (op == 2'b01) begin
        exp_q_n     = 1'b1;
        exp_valid_n = 1'b1;
      end else if (op == 2'b10) begin
        exp_q_n     = 1'b0;
        exp_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_idx    <= 16'd0;
      lfsr      <= LFSR_SEED;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      last_op_q <= 2'b00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_idx    <= op_idx_n;
      lfsr      <= lfsr_n;
      exp_q     <= exp_q_n;
      exp_valid <= exp_valid_n;
      s_q       <= s_n;
      r_q       <= r_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      pass_q    <= pass_n;
      err_q     <= err_n;
      last_op_q <= last_op_n;
    end
  end

  assign bus.s_out     = s_q;
  assign bus.r_out     = r_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.last_op   = last_op_q;

endmodule

// File: doc/sr_latch_exerciser.md
Name: sr_latch_exerciser

Overview:
On-chip stimulus driver and checker for the cross-coupled NOR SR latch. It drives the latch S/R inputs and reads back Q/Qn through a 2-flop synchronizer. Each response is compared against a reference model, and the block reports an error count plus a pass flag. The latch itself has no clock, so this block is its clocked counterpart and is wired between the latch and the top-level ui/uo pins.

Parameters:
SETTLE_CYCLES, 4, cycles S/R is held asserted, and also cycles of release before a check; must be >= 3
NUM_OPS, 16, operations per run; range 1..65535
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
mode  input  1  0 = fixed pattern, 1 = LFSR pseudo-random
s_out  output  1  latch S input
r_out  output  1  latch R input
q_in  input  1  latch Q, asynchronous to clk
qn_in  input  1  latch Qn, asynchronous to clk
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at the end of a run
pass  output  1  high when the last run finished with err_count == 0
err_count  output  ERR_W  mismatches in the last run, saturating
last_op  output  2  op code currently or most recently executed

Behaviour:
- Reset state (asynchronous, immediate):
  - FSM goes to IDLE.
  - s_out = r_out = 0, busy = done = pass = 0, err_count = 0, last_op = 0.
  - Synchronizer flops = 0, LFSR = 8'hA5, exp_q = 0, exp_valid = 0.
- Op codes:
  - 00 HOLD: S = R = 0.
  - 01 SET: S = 1.
  - 10 RESET: R = 1.
  - 11 maps to HOLD.
  - s_out and r_out are never high in the same cycle, under any condition.
- Op source:
  - mode 0: repeating SET, HOLD, RESET, HOLD.
  - mode 1: op = lfsr[1:0]. The LFSR is 8-bit Fibonacci, taps 8,6,5,4, and advances once per op on entry to DRIVE.
  - The LFSR is not reseeded by start.
- Synchronizer: q_in and qn_in each pass through 2 flops; checks use only the synchronized values.
- FSM:
  - IDLE: when start = 1, clear err_count, exp_valid and the op index, set busy, go to DRIVE. start is ignored in every other state.
  - DRIVE: drive S/R per op for SETTLE_CYCLES cycles, then go to RELEASE.
    - SET sets exp_q = 1 and exp_valid = 1.
    - RESET sets exp_q = 0 and exp_valid = 1.
    - HOLD leaves exp_q and exp_valid unchanged.
  - RELEASE: S = R = 0 for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK (1 cycle):
    - If exp_valid, it is a mismatch unless q_sync == exp_q and qn_sync == ~exp_q. Each mismatch increments err_count, saturating at 2^ERR_W-1.
    - If exp_valid = 0 (a HOLD before any SET/RESET), no check is made.
    - Then increment the op index. If it equals NUM_OPS go to DONE, else go to DRIVE.
  - DONE (1 cycle): done = 1; pass = (err_count == 0) after the final check's increment; busy = 0 from the next cycle; return to IDLE.
- Timing: start is sampled at edge k. busy is high from k+1. The done pulse occurs in cycle k+1+NUM_OPS*(2*SETTLE_CYCLES+1).
- Output retention: err_count and pass hold until the next accepted start or reset. pass is cleared when start is accepted.
- Invalid latch state: Q = Qn is always a mismatch when checked.
- Reset mid-run: s_out and r_out drop to 0 asynchronously. No done pulse is produced.

Test Plan:
- Ideal latch model, mode 0, defaults, start pulse → done exactly 145 cycles after start accepted; err_count = 0; pass = 1; busy high for 144 cycles.
- Q stuck at 0, Qn = ~Q, mode 0 → per 4 ops, the SET check and the following HOLD check fail; err_count = 8; pass = 0.
- Q = Qn = 0 forced, mode 0 → all 16 checks fail; err_count = 16.
- Q stuck at 0, mode 0, NUM_OPS = 600 → err_count saturates at 255 and does not wrap; pass = 0.
- Mode 1 with an assertion that s_out & r_out is never 1 and that s_out/r_out are 0 in RELEASE, CHECK and IDLE → assertion holds; with an ideal latch, err_count = 0; last_op tracks lfsr[1:0] starting from seed A5 (first op 01 SET).
- start re-pulsed while busy → ignored, run length unchanged. Reset asserted during DRIVE with SET → s_out = 0 in the same cycle, all outputs at reset values, no done pulse; a fresh start then runs normally.
